// File: rtl/pool_pkg.sv
// Shared types and helpers for the streaming 2D pooling engine.
package pool_pkg;
  localparam logic POOL_MAX = 1'b0;
  localparam logic POOL_AVG = 1'b1;

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH, DONE} pool_state_t;
  typedef enum logic [1:0] {OP_INIT, OP_MAX, OP_SUM} buf_op_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction
endpackage

// File: rtl/pool_line_buf.sv
// One partial result per output column; combinational read-modify, registered write.
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int DEPTH  = 5,
  parameter int ACC_W  = 18,
  parameter int IDX_W  = 3,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             en,
  input  buf_op_t          op,
  input  logic [IDX_W-1:0] idx,
  input  logic [ACC_W-1:0] din,
  output logic [ACC_W-1:0] result
);

  logic [ACC_W-1:0] mem [DEPTH];
  logic [ACC_W-1:0] cur;
  logic signed [ACC_W-1:0] din_s;
  logic signed [ACC_W-1:0] cur_s;
  logic greater;

  always_comb begin
    cur   = mem[idx];
    din_s = $signed(din);
    cur_s = $signed(cur);
    // Strict compare so that a tie keeps the value already stored.
    if (SIGNED != 0) greater = din_s > cur_s;
    else             greater = din > cur;
    case (op)
      OP_INIT: result = din;
      OP_MAX:  result = greater ? din : cur;
      default: result = cur + din;
    endcase
  end

  always_ff @(posedge clk) begin
    if (en) mem[idx] <= result;
  end

endmodule

// File: rtl/pool2d_stream.sv
// Streaming max/average pooling over a raster-order frame, writing results to an output RAM.
module pool2d_stream
  import pool_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int IN_ROWS    = 10,
  parameter int IN_COLS    = 10,
  parameter int POOL       = 2,
  parameter int SIGNED     = 1,
  parameter int ADDR_W     = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_position,
  input  logic                  pool_mode,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  busy,
  output logic                  out_wea,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [DATA_WIDTH-1:0] out_din,
  output logic                  pool_done
);

  localparam int SH       = clog2(POOL);
  localparam int OUT_ROWS = IN_ROWS / POOL;
  localparam int OUT_COLS = IN_COLS / POOL;
  localparam int ACC_W    = DATA_WIDTH + 2 * SH;
  localparam int RW       = (clog2(IN_ROWS) > SH) ? clog2(IN_ROWS) : SH;
  localparam int CW       = (clog2(IN_COLS) > SH) ? clog2(IN_COLS) : SH;
  localparam int IDX_W    = (OUT_COLS > 1) ? clog2(OUT_COLS) : 1;
  localparam int BUF_D    = (OUT_COLS > 0) ? OUT_COLS : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(IN_ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(IN_COLS - 1);

  function automatic logic [DATA_WIDTH-1:0] avg_scale(input logic [ACC_W-1:0] sum);
    logic signed [ACC_W-1:0] sum_s;
    logic [ACC_W-1:0] q;
    sum_s = $signed(sum);
    if (SIGNED != 0) q = sum_s >>> (2 * SH);
    else             q = sum >> (2 * SH);
    return q[DATA_WIDTH-1:0];
  endfunction

  pool_state_t state, state_nx;
  logic [RW-1:0]         row;
  logic [CW-1:0]         col;
  logic [ADDR_W-1:0]     base_q;
  logic                  mode_q;

  logic                  vld_p0, keep_p0, first_p0, last_p0, frame_end_p0;
  logic [SH-1:0]         rwin_p0, cwin_p0;
  logic [IDX_W-1:0]      oc_p0;
  logic [ACC_W-1:0]      ext_p0, comb_p0;
  logic [ADDR_W-1:0]     addr_p0;
  buf_op_t               op_p0;

  logic                  vld_p1;
  logic [ADDR_W-1:0]     addr_p1;
  logic [DATA_WIDTH-1:0] din_p1;

  // Stage p0: accept a sample, classify its window position, combine into the line buffer
  always_comb begin
    vld_p0       = in_valid && (state == BUSY);
    rwin_p0      = row[SH-1:0];
    cwin_p0      = col[SH-1:0];
    oc_p0        = IDX_W'(col >> SH);
    keep_p0      = vld_p0 && (int'(row) < OUT_ROWS * POOL) && (int'(col) < OUT_COLS * POOL);
    first_p0     = (rwin_p0 == '0) && (cwin_p0 == '0);
    last_p0      = (&rwin_p0) && (&cwin_p0);
    frame_end_p0 = (row == LAST_ROW) && (col == LAST_COL);
    if (SIGNED != 0) ext_p0 = {{(2 * SH){in_data[DATA_WIDTH-1]}}, in_data};
    else             ext_p0 = {{(2 * SH){1'b0}}, in_data};
    if (first_p0)                  op_p0 = OP_INIT;
    else if (mode_q == POOL_AVG)   op_p0 = OP_SUM;
    else                           op_p0 = OP_MAX;
    addr_p0 = base_q + ADDR_W'(int'(row >> SH) * OUT_COLS) + ADDR_W'(oc_p0);
  end

  pool_line_buf #(
    .DEPTH (BUF_D),
    .ACC_W (ACC_W),
    .IDX_W (IDX_W),
    .SIGNED(SIGNED)
  ) u_line_buf (
    .clk   (clk),
    .en    (keep_p0),
    .op    (op_p0),
    .idx   (oc_p0),
    .din   (ext_p0),
    .result(comb_p0)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row    <= '0;
      col    <= '0;
      base_q <= '0;
      mode_q <= POOL_MAX;
    end else if (start) begin
      row    <= '0;
      col    <= '0;
      base_q <= base_position;
      mode_q <= pool_mode;
    end else if (vld_p0) begin
      if (col == LAST_COL) begin
        col <= '0;
        row <= (row == LAST_ROW) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (start) begin
      state_nx = BUSY;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        BUSY:    if (vld_p0 && frame_end_p0) state_nx = FLUSH;
        FLUSH:   state_nx = DONE;
        DONE:    state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Stage p1: registered RAM write of a completed window
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      din_p1  <= '0;
    end else begin
      vld_p1 <= keep_p0 && last_p0;
      if (keep_p0 && last_p0) begin
        addr_p1 <= addr_p0;
        din_p1  <= (mode_q == POOL_AVG) ? avg_scale(comb_p0) : comb_p0[DATA_WIDTH-1:0];
      end
    end
  end

  assign busy      = (state != IDLE);
  assign pool_done = (state == DONE);
  assign out_wea   = vld_p1;
  assign out_addr  = addr_p1;
  assign out_din   = din_p1;

endmodule
